bp_mem_chan_arb: RTL and testbench
==================================

Name: bp_mem_chan_arb

Overview:
- Parametrised successor to the single-core chip top's single memory channel. It merges num_chan_p independent core-side mem_cmd streams onto one memory port using round-robin arbitration.
- Memory responses are steered back to the originating channel through an in-order source-ID FIFO.
- It sits between N softcore mem ports and the chip-level mem_cmd/mem_resp pins.
- Memory is decided to return responses strictly in command order.

Parameters:
- num_chan_p, 2, number of core-side channels (>=2).
- msg_width_p, 576, width of one mem command/response message.
- fifo_els_p, 8, maximum outstanding commands (power of 2, >=2).

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  reset, asynchronous assert, active-low.
- chan_cmd_i  in  num_chan_p*msg_width_p  per-channel command, channel k at bits [k*msg_width_p +: msg_width_p].
- chan_cmd_v_i  in  num_chan_p  per-channel command valid.
- chan_cmd_yumi_o  out  num_chan_p  command consumed this cycle (one-hot or zero).
- mem_cmd_o  out  msg_width_p  registered merged command.
- mem_cmd_v_o  out  1  mem_cmd_o valid.
- mem_cmd_ready_i  in  1  memory accepts mem_cmd_o when high with mem_cmd_v_o.
- mem_resp_i  in  msg_width_p  memory response.
- mem_resp_v_i  in  1  response valid.
- mem_resp_yumi_o  out  1  response consumed.
- chan_resp_o  out  msg_width_p  response data, broadcast to all channels.
- chan_resp_v_o  out  num_chan_p  one-hot valid to the owning channel.
- chan_resp_ready_i  in  num_chan_p  per-channel response ready.
- outstanding_o  out  $clog2(fifo_els_p+1)  current ID-FIFO occupancy.
- err_o  out  1  sticky: response received with no outstanding command.

Behaviour:
- Reset (async, reset_n_i low) clears:
  - outputs: mem_cmd_v_o=0, chan_cmd_yumi_o=0, mem_resp_yumi_o=0, chan_resp_v_o=0, outstanding_o=0, err_o=0;
  - internal state: round-robin pointer to 0, ID FIFO empty.
  - Reset mid-transaction discards buffered command and all IDs. No output glitches to valid during reset.
- Command path uses a one-entry output register (slot).
  - slot_free = !mem_cmd_v_o | mem_cmd_ready_i.
  - A grant occurs when slot_free & FIFO not full & any chan_cmd_v_i.
  - FIFO full blocks grants even if a pop occurs the same cycle.
- Arbitration is round-robin: scan from pointer p upward, modulo num_chan_p; the first valid channel k wins.
  - chan_cmd_yumi_o[k]=1 combinationally in the grant cycle.
  - On the next edge: mem_cmd_o<=chan_cmd_i[k], mem_cmd_v_o<=1, push k into ID FIFO, p<=(k+1) mod num_chan_p.
  - Without a grant, p holds.
- mem_cmd_v_o clears on ready handshake unless refilled the same cycle.
  - Back-to-back grants give one command per cycle when mem_cmd_ready_i stays high.
  - Latency is yumi to mem_cmd_v_o = 1 cycle.
- mem_cmd_o is stable while mem_cmd_v_o=1 and mem_cmd_ready_i=0.
- Response path is combinational (zero latency).
  - With the FIFO non-empty, let h be the FIFO head: chan_resp_v_o[h]=mem_resp_v_i, chan_resp_o=mem_resp_i, mem_resp_yumi_o=mem_resp_v_i & chan_resp_ready_i[h].
  - The FIFO pops on mem_resp_yumi_o.
  - A non-ready head channel stalls all responses (in-order, no bypass).
- With the FIFO empty and mem_resp_v_i=1: mem_resp_yumi_o=1 (drop), chan_resp_v_o=0, err_o<=1. err_o stays set until reset.
- The FIFO is a circular buffer: wr/rd pointers of $clog2(fifo_els_p) bits wrap modulo fifo_els_p.
  - Occupancy counter update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - outstanding_o equals the counter; full when counter==fifo_els_p.
- A push and pop in the same cycle with the FIFO empty is impossible, because a push lands one cycle after the grant.
  - The response for a command can arrive no earlier than the cycle after mem_cmd handshake.
- Assertions (sim only):
  - chan_cmd_yumi_o is one-hot0.
  - No push when full.

Test Plan:
- Reset, then channel 0 alone sends cmd A with ready=1 -> yumi[0] at cycle 0, mem_cmd_v_o and mem_cmd_o=A at cycle 1, outstanding_o=1. Response R -> chan_resp_v_o=2'b01, outstanding_o=0.
- num_chan_p=2, both valid continuously, ready=1 -> grants alternate 0,1,0,1 over 4 cycles. Responses R0..R3 route to 01,10,01,10.
- ready=0 held for 5 cycles with cmd B buffered -> mem_cmd_o stable at B, no further yumi; release -> next grant same cycle.
- fifo_els_p=8, memory withholds responses -> exactly 8 grants, outstanding_o=8, then no yumi. One response popped -> grant resumes the cycle after the pop.
- Head owner channel 1 has chan_resp_ready_i[1]=0 for 3 cycles -> mem_resp_yumi_o=0, channel 0 gets nothing. Ready rises -> delivery, pop.
- Response with empty FIFO -> mem_resp_yumi_o=1, chan_resp_v_o=0, err_o=1 sticky. Assert reset_n_i low mid-burst with outstanding_o=3 -> all outputs 0 immediately, pointer 0.

Source files
------------

// File: rtl/bp_mem_chan_arb.sv
// ============================================================================
// bp_mem_chan_arb : round-robin merge of N core mem_cmd streams onto one port,
//                   with in-order response steering via a source-ID FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bp_mem_chan_arb #(
  parameter int num_chan_p  = 2,
  parameter int msg_width_p = 576,
  parameter int fifo_els_p  = 8
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic [num_chan_p*msg_width_p-1:0]   chan_cmd_i,
  input  logic [num_chan_p-1:0]               chan_cmd_v_i,
  output logic [num_chan_p-1:0]               chan_cmd_yumi_o,
  output logic [msg_width_p-1:0]              mem_cmd_o,
  output logic                                mem_cmd_v_o,
  input  logic                                mem_cmd_ready_i,
  input  logic [msg_width_p-1:0]              mem_resp_i,
  input  logic                                mem_resp_v_i,
  output logic                                mem_resp_yumi_o,
  output logic [msg_width_p-1:0]              chan_resp_o,
  output logic [num_chan_p-1:0]               chan_resp_v_o,
  input  logic [num_chan_p-1:0]               chan_resp_ready_i,
  output logic [$clog2(fifo_els_p+1)-1:0]     outstanding_o,
  output logic                                err_o
);

  localparam int IDW = $clog2(num_chan_p);
  localparam int AW  = $clog2(fifo_els_p);
  localparam int CW  = $clog2(fifo_els_p + 1);

  logic [IDW-1:0]         rr_q, rr_d;
  logic [msg_width_p-1:0] cmd_q, cmd_d, cmd_sel;
  logic                   cmd_v_q, cmd_v_d;
  logic [AW-1:0]          wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic [IDW-1:0]         ids_q [fifo_els_p];

  logic [IDW:0]   scan;
  logic [IDW-1:0] win, head;
  logic           found, slot_free, full, empty, grant, pop;

  assign slot_free = !cmd_v_q | mem_cmd_ready_i;
  assign full      = (cnt_q == CW'(fifo_els_p));
  assign empty     = (cnt_q == '0);
  assign head      = ids_q[rd_q];

  // Round-robin scan starting at rr_q, wrapping modulo num_chan_p.
  always_comb begin
    scan  = '0;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < num_chan_p; i++) begin
      scan = {1'b0, rr_q} + (IDW+1)'(i);
      if (scan >= (IDW+1)'(num_chan_p)) scan = scan - (IDW+1)'(num_chan_p);
      if (!found && chan_cmd_v_i[scan[IDW-1:0]]) begin
        found = 1'b1;
        win   = scan[IDW-1:0];
      end
    end
  end

  // Every combinational handshake is gated by reset so nothing looks valid while held.
  assign grant = reset_n_i & slot_free & !full & found;

  always_comb begin
    chan_cmd_yumi_o = '0;
    chan_resp_v_o   = '0;
    cmd_sel         = '0;
    for (int k = 0; k < num_chan_p; k++) begin
      chan_cmd_yumi_o[k] = grant && (win == IDW'(k));
      chan_resp_v_o[k]   = reset_n_i && mem_resp_v_i && !empty && (head == IDW'(k));
      if (win == IDW'(k)) cmd_sel = chan_cmd_i[k*msg_width_p +: msg_width_p];
    end
  end

  // An orphan response (empty FIFO) is accepted and dropped, flagging err.
  assign mem_resp_yumi_o = reset_n_i & mem_resp_v_i & (empty | chan_resp_ready_i[head]);
  assign pop             = mem_resp_yumi_o & !empty;
  assign chan_resp_o     = mem_resp_i;

  always_comb begin
    cmd_d   = cmd_q;
    cmd_v_d = cmd_v_q;
    rr_d    = rr_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    err_d   = err_q | (mem_resp_yumi_o & empty);
    if (grant) begin
      cmd_d   = cmd_sel;
      cmd_v_d = 1'b1;
      rr_d    = (win == IDW'(num_chan_p - 1)) ? '0 : win + IDW'(1);
      wr_d    = wr_q + AW'(1);
    end else if (mem_cmd_ready_i) begin
      cmd_v_d = 1'b0;
    end
    if (pop) rd_d = rd_q + AW'(1);
    case ({grant, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cmd_q   <= '0;
      cmd_v_q <= 1'b0;
      rr_q    <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      cmd_q   <= cmd_d;
      cmd_v_q <= cmd_v_d;
      rr_q    <= rr_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (grant) ids_q[wr_q] <= win;
  end

  assign mem_cmd_o     = cmd_q;
  assign mem_cmd_v_o   = cmd_v_q;
  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

`ifndef SYNTHESIS
  a_yumi_onehot0: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    $onehot0(chan_cmd_yumi_o));
  a_no_push_full: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(grant && full));
`endif

endmodule

`default_nettype wire

// File: tb/tb_bp_mem_chan_arb.sv
// ============================================================================
// tb_bp_mem_chan_arb : directed self-checking bench for bp_mem_chan_arb.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bp_mem_chan_arb;

  localparam int N  = 2;
  localparam int W  = 16;
  localparam int FE = 8;
  localparam int CW = $clog2(FE + 1);

  logic           clk_i = 1'b0;
  logic           reset_n_i;
  logic [N*W-1:0] chan_cmd_i;
  logic [N-1:0]   chan_cmd_v_i;
  logic [N-1:0]   chan_cmd_yumi_o;
  logic [W-1:0]   mem_cmd_o;
  logic           mem_cmd_v_o;
  logic           mem_cmd_ready_i;
  logic [W-1:0]   mem_resp_i;
  logic           mem_resp_v_i;
  logic           mem_resp_yumi_o;
  logic [W-1:0]   chan_resp_o;
  logic [N-1:0]   chan_resp_v_o;
  logic [N-1:0]   chan_resp_ready_i;
  logic [CW-1:0]  outstanding_o;
  logic           err_o;

  int errors = 0;
  int checks = 0;

  bp_mem_chan_arb #(.num_chan_p(N), .msg_width_p(W), .fifo_els_p(FE)) dut (
    .clk_i             (clk_i),
    .reset_n_i         (reset_n_i),
    .chan_cmd_i        (chan_cmd_i),
    .chan_cmd_v_i      (chan_cmd_v_i),
    .chan_cmd_yumi_o   (chan_cmd_yumi_o),
    .mem_cmd_o         (mem_cmd_o),
    .mem_cmd_v_o       (mem_cmd_v_o),
    .mem_cmd_ready_i   (mem_cmd_ready_i),
    .mem_resp_i        (mem_resp_i),
    .mem_resp_v_i      (mem_resp_v_i),
    .mem_resp_yumi_o   (mem_resp_yumi_o),
    .chan_resp_o       (chan_resp_o),
    .chan_resp_v_o     (chan_resp_v_o),
    .chan_resp_ready_i (chan_resp_ready_i),
    .outstanding_o     (outstanding_o),
    .err_o             (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic apply_reset();
    reset_n_i         = 1'b0;
    chan_cmd_i        = '0;
    chan_cmd_v_i      = '0;
    mem_cmd_ready_i   = 1'b1;
    mem_resp_i        = '0;
    mem_resp_v_i      = 1'b0;
    chan_resp_ready_i = '1;
    tick();
    tick();
    reset_n_i = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++; if (mem_cmd_v_o !== 1'b0) begin errors++; $display("FAIL reset_cmd_v: got %b want 0", mem_cmd_v_o); end
    checks++; if (chan_cmd_yumi_o !== 2'b00) begin errors++; $display("FAIL reset_yumi: got %b want 00", chan_cmd_yumi_o); end
    checks++; if (mem_resp_yumi_o !== 1'b0) begin errors++; $display("FAIL reset_resp_yumi: got %b want 0", mem_resp_yumi_o); end
    checks++; if (chan_resp_v_o !== 2'b00) begin errors++; $display("FAIL reset_resp_v: got %b want 00", chan_resp_v_o); end
    checks++; if (outstanding_o !== 4'd0) begin errors++; $display("FAIL reset_outstanding: got %0d want 0", outstanding_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_o); end
  endtask

  task automatic test_single();
    apply_reset();
    chan_cmd_i   = {16'h0000, 16'hA5A5};
    chan_cmd_v_i = 2'b01;
    #1;
    checks++; if (chan_cmd_yumi_o !== 2'b01) begin errors++; $display("FAIL single_yumi: got %b want 01", chan_cmd_yumi_o); end
    tick();
    chan_cmd_v_i = 2'b00;
    checks++; if (mem_cmd_v_o !== 1'b1) begin errors++; $display("FAIL single_cmd_v: got %b want 1", mem_cmd_v_o); end
    checks++; if (mem_cmd_o !== 16'hA5A5) begin errors++; $display("FAIL single_cmd: got %h want a5a5", mem_cmd_o); end
    checks++; if (outstanding_o !== 4'd1) begin errors++; $display("FAIL single_outstanding: got %0d want 1", outstanding_o); end
    tick();
    checks++; if (mem_cmd_v_o !== 1'b0) begin errors++; $display("FAIL single_cmd_drain: got %b want 0", mem_cmd_v_o); end
    mem_resp_i   = 16'h1234;
    mem_resp_v_i = 1'b1;
    #1;
    checks++; if (chan_resp_v_o !== 2'b01) begin errors++; $display("FAIL single_resp_v: got %b want 01", chan_resp_v_o); end
    checks++; if (chan_resp_o !== 16'h1234) begin errors++; $display("FAIL single_resp_data: got %h want 1234", chan_resp_o); end
    checks++; if (mem_resp_yumi_o !== 1'b1) begin errors++; $display("FAIL single_resp_yumi: got %b want 1", mem_resp_yumi_o); end
    tick();
    mem_resp_v_i = 1'b0;
    checks++; if (outstanding_o !== 4'd0) begin errors++; $display("FAIL single_outstanding_end: got %0d want 0", outstanding_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", err_o); end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] exp_v;
    logic [W-1:0] exp_d;
    apply_reset();
    chan_cmd_i   = {16'hC1C1, 16'hC0C0};
    chan_cmd_v_i = 2'b11;
    for (int i = 0; i < 4; i++) begin
      exp_v = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_d = (i % 2 == 0) ? 16'hC0C0 : 16'hC1C1;
      #1;
      checks++; if (chan_cmd_yumi_o !== exp_v) begin errors++; $display("FAIL b2b_yumi[%0d]: got %b want %b", i, chan_cmd_yumi_o, exp_v); end
      tick();
      checks++; if (mem_cmd_o !== exp_d) begin errors++; $display("FAIL b2b_cmd[%0d]: got %h want %h", i, mem_cmd_o, exp_d); end
    end
    chan_cmd_v_i = 2'b00;
    tick();
    checks++; if (outstanding_o !== 4'd4) begin errors++; $display("FAIL b2b_outstanding: got %0d want 4", outstanding_o); end
    mem_resp_v_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_v      = (i % 2 == 0) ? 2'b01 : 2'b10;
      mem_resp_i = 16'h5000 + 16'(i);
      #1;
      checks++; if (chan_resp_v_o !== exp_v) begin errors++; $display("FAIL b2b_resp_v[%0d]: got %b want %b", i, chan_resp_v_o, exp_v); end
      tick();
    end
    mem_resp_v_i = 1'b0;
    checks++; if (outstanding_o !== 4'd0) begin errors++; $display("FAIL b2b_drained: got %0d want 0", outstanding_o); end
  endtask

  task automatic test_stall();
    apply_reset();
    chan_cmd_i      = {16'hDDDD, 16'hBBBB};
    chan_cmd_v_i    = 2'b01;
    mem_cmd_ready_i = 1'b0;
    #1;
    checks++; if (chan_cmd_yumi_o !== 2'b01) begin errors++; $display("FAIL stall_first_yumi: got %b want 01", chan_cmd_yumi_o); end
    tick();
    chan_cmd_v_i = 2'b10;
    for (int i = 0; i < 5; i++) begin
      checks++; if (mem_cmd_o !== 16'hBBBB) begin errors++; $display("FAIL stall_cmd[%0d]: got %h want bbbb", i, mem_cmd_o); end
      #1;
      checks++; if (chan_cmd_yumi_o !== 2'b00) begin errors++; $display("FAIL stall_yumi[%0d]: got %b want 00", i, chan_cmd_yumi_o); end
      tick();
    end
    mem_cmd_ready_i = 1'b1;
    #1;
    checks++; if (chan_cmd_yumi_o !== 2'b10) begin errors++; $display("FAIL stall_release_yumi: got %b want 10", chan_cmd_yumi_o); end
    tick();
    chan_cmd_v_i = 2'b00;
    checks++; if (mem_cmd_o !== 16'hDDDD) begin errors++; $display("FAIL stall_next_cmd: got %h want dddd", mem_cmd_o); end
    checks++; if (mem_cmd_v_o !== 1'b1) begin errors++; $display("FAIL stall_next_v: got %b want 1", mem_cmd_v_o); end
  endtask

  task automatic test_fifo_full();
    int grants;
    apply_reset();
    grants       = 0;
    chan_cmd_i   = {16'h0000, 16'h1111};
    chan_cmd_v_i = 2'b01;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (chan_cmd_yumi_o[0]) grants++;
      tick();
    end
    checks++; if (grants !== 8) begin errors++; $display("FAIL full_grants: got %0d want 8", grants); end
    checks++; if (outstanding_o !== 4'd8) begin errors++; $display("FAIL full_outstanding: got %0d want 8", outstanding_o); end
    mem_resp_v_i = 1'b1;
    #1;
    checks++; if (mem_resp_yumi_o !== 1'b1) begin errors++; $display("FAIL full_pop: got %b want 1", mem_resp_yumi_o); end
    checks++; if (chan_cmd_yumi_o !== 2'b00) begin errors++; $display("FAIL full_blocks_same_cycle: got %b want 00", chan_cmd_yumi_o); end
    tick();
    mem_resp_v_i = 1'b0;
    checks++; if (outstanding_o !== 4'd7) begin errors++; $display("FAIL full_after_pop: got %0d want 7", outstanding_o); end
    #1;
    checks++; if (chan_cmd_yumi_o !== 2'b01) begin errors++; $display("FAIL full_resume: got %b want 01", chan_cmd_yumi_o); end
    tick();
    chan_cmd_v_i = 2'b00;
    checks++; if (outstanding_o !== 4'd8) begin errors++; $display("FAIL full_refill: got %0d want 8", outstanding_o); end
  endtask

  task automatic test_head_block();
    apply_reset();
    chan_cmd_i   = {16'h2222, 16'h3333};
    chan_cmd_v_i = 2'b10;
    #1;
    checks++; if (chan_cmd_yumi_o !== 2'b10) begin errors++; $display("FAIL hol_yumi1: got %b want 10", chan_cmd_yumi_o); end
    tick();
    chan_cmd_v_i = 2'b01;
    #1;
    checks++; if (chan_cmd_yumi_o !== 2'b01) begin errors++; $display("FAIL hol_yumi0: got %b want 01", chan_cmd_yumi_o); end
    tick();
    chan_cmd_v_i = 2'b00;
    tick();
    checks++; if (outstanding_o !== 4'd2) begin errors++; $display("FAIL hol_outstanding: got %0d want 2", outstanding_o); end
    mem_resp_i        = 16'h7777;
    mem_resp_v_i      = 1'b1;
    chan_resp_ready_i = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (mem_resp_yumi_o !== 1'b0) begin errors++; $display("FAIL hol_stall_yumi[%0d]: got %b want 0", i, mem_resp_yumi_o); end
      checks++; if (chan_resp_v_o !== 2'b10) begin errors++; $display("FAIL hol_stall_v[%0d]: got %b want 10", i, chan_resp_v_o); end
      tick();
    end
    checks++; if (outstanding_o !== 4'd2) begin errors++; $display("FAIL hol_held: got %0d want 2", outstanding_o); end
    chan_resp_ready_i = 2'b11;
    #1;
    checks++; if (mem_resp_yumi_o !== 1'b1) begin errors++; $display("FAIL hol_release_yumi: got %b want 1", mem_resp_yumi_o); end
    tick();
    #1;
    checks++; if (chan_resp_v_o !== 2'b01) begin errors++; $display("FAIL hol_next_head: got %b want 01", chan_resp_v_o); end
    tick();
    mem_resp_v_i = 1'b0;
    checks++; if (outstanding_o !== 4'd0) begin errors++; $display("FAIL hol_drained: got %0d want 0", outstanding_o); end
  endtask

  task automatic test_err_and_reset();
    apply_reset();
    mem_resp_i   = 16'hDEAD;
    mem_resp_v_i = 1'b1;
    #1;
    checks++; if (mem_resp_yumi_o !== 1'b1) begin errors++; $display("FAIL orphan_yumi: got %b want 1", mem_resp_yumi_o); end
    checks++; if (chan_resp_v_o !== 2'b00) begin errors++; $display("FAIL orphan_resp_v: got %b want 00", chan_resp_v_o); end
    tick();
    mem_resp_v_i = 1'b0;
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL orphan_err: got %b want 1", err_o); end
    tick();
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL orphan_err_sticky: got %b want 1", err_o); end
    chan_cmd_i   = {16'h4444, 16'h5555};
    chan_cmd_v_i = 2'b01;
    tick();
    tick();
    tick();
    chan_cmd_v_i = 2'b11;
    checks++; if (outstanding_o !== 4'd3) begin errors++; $display("FAIL burst_outstanding: got %0d want 3", outstanding_o); end
    #2;
    mem_resp_v_i = 1'b1;
    reset_n_i    = 1'b0;
    #1;
    checks++; if (mem_cmd_v_o !== 1'b0) begin errors++; $display("FAIL async_cmd_v: got %b want 0", mem_cmd_v_o); end
    checks++; if (chan_cmd_yumi_o !== 2'b00) begin errors++; $display("FAIL async_yumi: got %b want 00", chan_cmd_yumi_o); end
    checks++; if (mem_resp_yumi_o !== 1'b0) begin errors++; $display("FAIL async_resp_yumi: got %b want 0", mem_resp_yumi_o); end
    checks++; if (chan_resp_v_o !== 2'b00) begin errors++; $display("FAIL async_resp_v: got %b want 00", chan_resp_v_o); end
    checks++; if (outstanding_o !== 4'd0) begin errors++; $display("FAIL async_outstanding: got %0d want 0", outstanding_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL async_err: got %b want 0", err_o); end
    mem_resp_v_i = 1'b0;
    tick();
    reset_n_i = 1'b1;
    #1;
    checks++; if (chan_cmd_yumi_o !== 2'b01) begin errors++; $display("FAIL async_ptr_zero: got %b want 01", chan_cmd_yumi_o); end
    tick();
    chan_cmd_v_i = 2'b00;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_fifo_full();
    test_head_block();
    test_err_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
